frame_wr_addr_gen: RTL and testbench

- Per-slave DDR write-side address generator. It sits directly downstream of the bank switcher and consumes its wr_load/wr_bank outputs.
- Drains a pixel write FIFO in fixed-length bursts and issues burst write commands with address {wr_bank, offset} to the DDR user port.
- Returns a one-cycle frame_wr_done pulse to the bank switcher when a full frame has been written.
- One instance per slave (4 total), all on ddr_clk.

---
 rtl/frame_wr_pkg.sv | 27 ++
 rtl/frame_wr_burst_cnt.sv | 55 +++++
 rtl/frame_wr_addr_gen.sv | 200 ++++++++++++++++++++
 tb/tb_frame_wr_addr_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_wr_pkg.sv
// Shared definitions for the per-slave DDR frame write address generator:
// FSM state encoding, bank field geometry and default sizing.
package frame_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_CMD       = 3'd2,
    ST_DATA      = 3'd3,
    ST_DONE      = 3'd4
  } wr_state_e;

  // Bank select occupies the top two bits of the DDR word address.
  localparam int BANK_W = 2;

  localparam int DEF_ADDR_W       = 25;
  localparam int DEF_BURST_LEN    = 64;
  localparam int DEF_ADDR_STEP    = 8;
  localparam int DEF_FRAME_BURSTS = 1800;
  localparam int DEF_FIFO_CNT_W   = 10;

  // LSB position of the bank field, which is also the width of the offset.
  function automatic int bank_lsb(input int addr_w);
    return addr_w - BANK_W;
  endfunction

endpackage

// File: rtl/frame_wr_burst_cnt.sv
// Beat and burst counters for the frame write address generator.
// beat_last flags the final beat of a burst, frame_last flags the final
// burst of a frame; both are decoded from the current counter values.
module frame_wr_burst_cnt #(
  parameter int BURST_LEN    = 64,
  parameter int FRAME_BURSTS = 1800
) (
  input  logic ddr_clk,
  input  logic sys_rstn,
  input  logic frame_clr,
  input  logic beat_clr,
  input  logic beat_inc,
  output logic beat_last,
  output logic frame_last
);

  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(FRAME_BURSTS - 1);

  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  assign beat_last  = (beat_cnt_q == BEAT_MAX);
  assign frame_last = (burst_cnt_q == BURST_MAX);

  // Next count: clears win over increments; both counters roll to 0 at terminal count.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (frame_clr || beat_clr) begin
      beat_cnt_d = '0;
    end else if (beat_inc) begin
      beat_cnt_d = beat_last ? '0 : beat_cnt_q + 1'b1;
    end
    if (frame_clr) begin
      burst_cnt_d = '0;
    end else if (beat_inc && beat_last) begin
      burst_cnt_d = frame_last ? '0 : burst_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/frame_wr_addr_gen.sv
// Per-slave DDR write-side address generator. Drains the pixel write FIFO in
// fixed bursts, issuing one write command per burst at {bank, offset}, and
// pulses frame_wr_done once a whole frame has been written.
// Optional build macro FRAME_WR_STATUS_EN adds frame_cnt and frame_abort.
module frame_wr_addr_gen
  import frame_wr_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int ADDR_STEP    = DEF_ADDR_STEP,
  parameter int FRAME_BURSTS = DEF_FRAME_BURSTS,
  parameter int FIFO_CNT_W   = DEF_FIFO_CNT_W
) (
  input  logic                  ddr_clk,
  input  logic                  sys_rstn,
  input  logic                  wr_load,
  input  logic [BANK_W-1:0]     wr_bank,
  input  logic [FIFO_CNT_W-1:0] fifo_rd_cnt,
  output logic                  fifo_rd_en,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_W-1:0]     cmd_addr,
  input  logic                  wdata_ready,
  output logic                  busy,
  output logic                  frame_wr_done
`ifdef FRAME_WR_STATUS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic                  frame_abort
`endif
);

  localparam int OFF_W = bank_lsb(ADDR_W);
  localparam logic [OFF_W-1:0]      OFF_INC   = OFF_W'(BURST_LEN * ADDR_STEP);
  localparam logic [FIFO_CNT_W-1:0] BURST_THR = FIFO_CNT_W'(BURST_LEN);

  wr_state_e         state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] pend_bank_q, pend_bank_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              load_pend_q, load_pend_d;

  logic              restart;
  logic [BANK_W-1:0] restart_bank;
  logic              frame_clr, beat_clr, beat_inc;
  logic              beat_last, frame_last;

  frame_wr_burst_cnt #(
    .BURST_LEN    (BURST_LEN),
    .FRAME_BURSTS (FRAME_BURSTS)
  ) u_burst_cnt (
    .ddr_clk    (ddr_clk),
    .sys_rstn   (sys_rstn),
    .frame_clr  (frame_clr),
    .beat_clr   (beat_clr),
    .beat_inc   (beat_inc),
    .beat_last  (beat_last),
    .frame_last (frame_last)
  );

  assign busy     = (state_q != ST_IDLE);
  assign cmd_addr = {bank_q, offset_q};

  // Next-state and output decode; a frame restart is collected into one path at the end.
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    pend_bank_d   = pend_bank_q;
    offset_d      = offset_q;
    load_pend_d   = load_pend_q;
    restart       = 1'b0;
    restart_bank  = wr_bank;
    frame_clr     = 1'b0;
    beat_clr      = 1'b0;
    beat_inc      = 1'b0;
    cmd_valid     = 1'b0;
    fifo_rd_en    = 1'b0;
    frame_wr_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_load) begin
          restart = 1'b1;
        end
      end

      ST_WAIT_DATA: begin
        // A new load abandons the frame before any command of this burst is issued.
        if (wr_load) begin
          restart = 1'b1;
        end else if (fifo_rd_cnt >= BURST_THR) begin
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        cmd_valid = 1'b1;
        if (wr_load) begin
          load_pend_d = 1'b1;
          pend_bank_d = wr_bank;
        end
        if (cmd_ready) begin
          beat_clr = 1'b1;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        fifo_rd_en = wdata_ready;
        beat_inc   = wdata_ready;
        if (wr_load) begin
          load_pend_d = 1'b1;
          pend_bank_d = wr_bank;
        end
        if (wdata_ready && beat_last) begin
          offset_d = offset_q + OFF_INC;
          // A burst is never truncated; a load seen during it takes effect here.
          if (load_pend_q || wr_load) begin
            restart      = 1'b1;
            restart_bank = wr_load ? wr_bank : pend_bank_q;
          end else if (frame_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end

      ST_DONE: begin
        frame_wr_done = 1'b1;
        if (wr_load) begin
          restart = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (restart) begin
      bank_d      = restart_bank;
      offset_d    = '0;
      load_pend_d = 1'b0;
      frame_clr   = 1'b1;
      state_d     = ST_WAIT_DATA;
    end
  end

  // State, address and pending-load registers.
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      pend_bank_q <= '0;
      offset_q    <= '0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      pend_bank_q <= pend_bank_d;
      offset_q    <= offset_d;
      load_pend_q <= load_pend_d;
    end
  end

`ifdef FRAME_WR_STATUS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_abort_q, frame_abort_d;

  // Frame counter wraps naturally; abort flag is sticky until reset.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    frame_abort_d = frame_abort_q;
    if (state_q == ST_DONE) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (wr_load && (state_q == ST_WAIT_DATA || state_q == ST_CMD || state_q == ST_DATA)) begin
      frame_abort_d = 1'b1;
    end
  end

  // Status registers.
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      frame_cnt_q   <= '0;
      frame_abort_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign frame_abort = frame_abort_q;
`endif

endmodule

// File: tb/tb_frame_wr_addr_gen.sv
// Self-checking bench for frame_wr_addr_gen with a small frame geometry.
module tb_frame_wr_addr_gen;

  localparam int AW   = 25;
  localparam int BL   = 4;
  localparam int STEP = 8;
  localparam int FB   = 3;
  localparam int CW   = 10;

  logic          ddr_clk;
  logic          sys_rstn;
  logic          wr_load;
  logic [1:0]    wr_bank;
  logic [CW-1:0] fifo_rd_cnt;
  logic          fifo_rd_en;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          wdata_ready;
  logic          busy;
  logic          frame_wr_done;
`ifdef FRAME_WR_STATUS_EN
  logic [15:0]   frame_cnt;
  logic          frame_abort;
`endif

  frame_wr_addr_gen #(
    .ADDR_W       (AW),
    .BURST_LEN    (BL),
    .ADDR_STEP    (STEP),
    .FRAME_BURSTS (FB),
    .FIFO_CNT_W   (CW)
  ) dut (
    .ddr_clk       (ddr_clk),
    .sys_rstn      (sys_rstn),
    .wr_load       (wr_load),
    .wr_bank       (wr_bank),
    .fifo_rd_cnt   (fifo_rd_cnt),
    .fifo_rd_en    (fifo_rd_en),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .wdata_ready   (wdata_ready),
    .busy          (busy),
    .frame_wr_done (frame_wr_done)
`ifdef FRAME_WR_STATUS_EN
    ,
    .frame_cnt     (frame_cnt),
    .frame_abort   (frame_abort)
`endif
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame progress as phase + bursts done; address = bank : k*BL*STEP.
  // Phases: 0 idle, 1 waiting for FIFO data, 2 offering command, 3 moving beats, 4 frame done.
  int         m_phase, m_k, m_beats, m_pend, m_fcnt, m_abort;
  logic [1:0] m_bank, m_pbank;

  function automatic logic [AW-1:0] m_addr();
    longint     off;
    logic [22:0] o;
    off = (longint'(m_k) * BL * STEP) % (longint'(1) << 23);
    o = off[22:0];
    return {m_bank, o};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_beats = 0; m_pend = 0;
    m_bank = 2'd0; m_pbank = 2'd0; m_fcnt = 0; m_abort = 0;
  endtask

  task automatic model_restart(input logic [1:0] b);
    m_bank = b; m_k = 0; m_pend = 0; m_phase = 1;
  endtask

  task automatic model_step();
    if (m_phase == 4) m_fcnt = (m_fcnt + 1) % 65536;
    if (wr_load && m_phase >= 1 && m_phase <= 3) m_abort = 1;
    case (m_phase)
      0: if (wr_load) model_restart(wr_bank);
      1: begin
        if (wr_load) model_restart(wr_bank);
        else if (int'(fifo_rd_cnt) >= BL) m_phase = 2;
      end
      2: begin
        if (wr_load) begin m_pend = 1; m_pbank = wr_bank; end
        if (cmd_ready) begin m_phase = 3; m_beats = 0; end
      end
      3: begin
        if (wr_load) begin m_pend = 1; m_pbank = wr_bank; end
        if (wdata_ready) begin
          m_beats++;
          if (m_beats == BL) begin
            m_k++;
            if (m_pend != 0) model_restart(m_pbank);
            else if (m_k == FB) m_phase = 4;
            else m_phase = 1;
          end
        end
      end
      default: begin
        if (wr_load) model_restart(wr_bank);
        else m_phase = 0;
      end
    endcase
  endtask

  // Observation log for the directed scenarios.
  logic [AW-1:0] cmd_log[$];
  int rd_cnt, done_cnt, cv_cnt;
  logic obs_cv, obs_rd, obs_busy;
  logic [AW-1:0] obs_addr;

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic [AW+3:0] exp_v;
    @(negedge ddr_clk);
    if (!sys_rstn) begin
      model_reset();
      exp_v = '0;
    end else begin
      exp_v = {(m_phase != 0), (m_phase == 2), (m_phase == 3) && wdata_ready,
               (m_phase == 4), m_addr()};
    end
    check_eq("cycle", {busy, cmd_valid, fifo_rd_en, frame_wr_done, cmd_addr}, exp_v);
`ifdef FRAME_WR_STATUS_EN
    check_eq("frame_cnt", frame_cnt, m_fcnt);
    check_eq("frame_abort", frame_abort, m_abort);
`endif
    obs_cv = cmd_valid; obs_rd = fifo_rd_en; obs_busy = busy; obs_addr = cmd_addr;
    if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_addr);
    if (fifo_rd_en) rd_cnt++;
    if (frame_wr_done) done_cnt++;
    if (cmd_valid) cv_cnt++;
    if (sys_rstn) model_step();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic pulse_load(input logic [1:0] b);
    wr_load = 1'b1;
    wr_bank = b;
    tick();
    wr_load = 1'b0;
  endtask

  task automatic clear_obs();
    cmd_log.delete();
    rd_cnt = 0; done_cnt = 0; cv_cnt = 0;
  endtask

  initial begin
    logic [3:0] rd_pat;
    int guard;

    sys_rstn = 1'b1; wr_load = 1'b0; wr_bank = 2'd0;
    fifo_rd_cnt = '0; cmd_ready = 1'b0; wdata_ready = 1'b0;
    model_reset();
    clear_obs();
    #2 sys_rstn = 1'b0;
    tick(); tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cmd_valid", cmd_valid, 1'b0);
    sys_rstn = 1'b1;
    tick();

    // Full frame, bank 2, everything ready.
    fifo_rd_cnt = 10'd16; cmd_ready = 1'b1; wdata_ready = 1'b1;
    clear_obs();
    pulse_load(2'd2);
    guard = 0;
    while (done_cnt == 0 && guard < 60) begin tick(); guard++; end
    tick(); tick();
    check_eq("t1_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() == 3) begin
      check_eq("t1_addr0", cmd_log[0], 25'h1000000);
      check_eq("t1_addr1", cmd_log[1], 25'h1000020);
      check_eq("t1_addr2", cmd_log[2], 25'h1000040);
    end
    check_eq("t1_rd_beats", rd_cnt, 12);
    check_eq("t1_done", done_cnt, 1);
    check_eq("t1_busy_after", obs_busy, 1'b0);

    // FIFO below threshold holds off the command.
    clear_obs();
    fifo_rd_cnt = 10'd3; cmd_ready = 1'b0; wdata_ready = 1'b0;
    pulse_load(2'd3);
    repeat (6) tick();
    check_eq("t2_no_cmd", cv_cnt, 0);
    fifo_rd_cnt = 10'd4;
    tick();
    // Command held while cmd_ready is low.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_cv_hold", obs_cv, 1'b1);
      check_eq("t3_addr_hold", obs_addr, 25'h1800000);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    rd_cnt = 0;
    rd_pat = '0;
    for (int i = 0; i < 7; i++) begin
      wdata_ready = (i % 2 == 0);
      tick();
      if (i < 4) rd_pat = {rd_pat[2:0], obs_rd};
    end
    fifo_rd_cnt = '0; wdata_ready = 1'b0;
    repeat (3) tick();
    check_eq("t3_rd_pat", rd_pat, 4'b1010);
    check_eq("t3_beats", rd_cnt, 4);
    check_eq("t3_ncmd", cmd_log.size(), 1);

    // Load during beat 2 of burst 2: burst finishes, frame restarts in bank 1.
    fifo_rd_cnt = 10'd16; cmd_ready = 1'b1; wdata_ready = 1'b1;
    pulse_load(2'd2);
    clear_obs();
    guard = 0;
    while (cmd_log.size() < 2 && guard < 40) begin tick(); guard++; end
    rd_cnt = 0;
    tick(); tick();
    pulse_load(2'd1);
    guard = 0;
    while (cmd_log.size() < 3 && guard < 40) begin tick(); guard++; end
    check_eq("t4_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() == 3) begin
      check_eq("t4_addr1", cmd_log[1], 25'h1000020);
      check_eq("t4_addr2", cmd_log[2], 25'h0800000);
    end
    check_eq("t4_beats", rd_cnt, 4);
    check_eq("t4_no_done", done_cnt, 0);

    // Asynchronous reset while moving beats.
    guard = 0;
    while (m_phase != 3 && guard < 20) begin tick(); guard++; end
    check_eq("t5_rd_pre", fifo_rd_en, 1'b1);
    #1 sys_rstn = 1'b0;
    #1;
    check_eq("t5_rd_async", fifo_rd_en, 1'b0);
    check_eq("t5_cv_async", cmd_valid, 1'b0);
    check_eq("t5_busy_async", busy, 1'b0);
    model_reset();
    tick(); tick();
    sys_rstn = 1'b1;
    repeat (4) tick();
    check_eq("t5_idle", obs_busy, 1'b0);

    // Two complete frames, then a mid-frame reload.
    clear_obs();
    pulse_load(2'd0);
    guard = 0;
    while (done_cnt < 1 && guard < 60) begin tick(); guard++; end
    pulse_load(2'd1);
    guard = 0;
    while (done_cnt < 2 && guard < 60) begin tick(); guard++; end
    tick();
    pulse_load(2'd2);
    guard = 0;
    while (m_phase != 3 && guard < 20) begin tick(); guard++; end
    pulse_load(2'd3);
    tick();
    check_eq("t6_done", done_cnt, 2);
`ifdef FRAME_WR_STATUS_EN
    check_eq("t6_frame_cnt", frame_cnt, 16'd2);
    check_eq("t6_frame_abort", frame_abort, 1'b1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_load     = ($urandom_range(0, 39) == 0);
      wr_bank     = 2'($urandom_range(0, 3));
      fifo_rd_cnt = CW'($urandom_range(0, 8));
      cmd_ready   = ($urandom_range(0, 2) != 0);
      wdata_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
